// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins, a starvation guard forces a fetch grant.
// One arbitration cycle plus RAM time (min 2 cycles); each side stalls on iwait/dwait until ramstate reports ACCESS.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, next_state;
  logic [3:0] starve, next_starve;
  logic       dreq;
  logic       force_igrant;
  logic       done;

  assign dreq         = dREN | dWEN;
  assign force_igrant = iREN & (starve == STARVE_LIM);
  assign done         = (ramstate == ACCESS);
  assign iload        = ramload;
  assign dload        = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= next_state;
      starve <= next_starve;
    end
  end

  always_comb begin
    next_state  = state;
    next_starve = starve;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = iREN;
    dwait       = dreq;

    unique case (state)
      IDLE: begin
        if (dreq && !force_igrant) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~done;
        if (done) begin
          next_state = IDLE;
          // Count data wins only while a fetch is actually waiting
          if (!iREN) begin
            next_starve = '0;
          end else if (starve != STARVE_LIM) begin
            next_starve = starve + 4'd1;
          end
        end else if (ramstate == ERROR || !dreq) begin
          next_state = IDLE;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~done;
        if (done) begin
          next_state  = IDLE;
          next_starve = '0;
        end else if (ramstate == ERROR || !iREN) begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level owner/streak model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  int tests = 0;
  int fails = 0;
  // owner: 0 = nobody, 1 = instruction side, 2 = data side
  int owner  = 0;
  int streak = 0;
  int i_done = 0;
  int d_done = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle from who owns the port
  task automatic sample(input string tag);
    logic        dq, e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    @(negedge CLK);
    dq      = dREN | dWEN;
    e_addr  = 32'h0;
    e_store = 32'h0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_iw    = iREN;
    e_dw    = dq;
    if (owner == 1) begin
      e_addr = iaddr;
      e_ren  = iREN;
      e_iw   = (ramstate != ACCESS);
    end else if (owner == 2) begin
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_dw    = (ramstate != ACCESS);
    end
    chk({tag, "_iwait"},    32'(iwait),       32'(e_iw));
    chk({tag, "_dwait"},    32'(dwait),       32'(e_dw));
    chk({tag, "_ramREN"},   32'(ramREN),      32'(e_ren));
    chk({tag, "_ramWEN"},   32'(ramWEN),      32'(e_wen));
    chk({tag, "_ramaddr"},  ramaddr,          e_addr);
    chk({tag, "_ramstore"}, ramstore,         e_store);
    chk({tag, "_iload"},    iload,            ramload);
    chk({tag, "_dload"},    dload,            ramload);
    chk({tag, "_starve"},   32'(dut.starve),  32'(streak));
  endtask

  // Move the model forward one clock using this cycle's inputs
  task automatic tick();
    logic dq;
    dq     = dREN | dWEN;
    i_done = 0;
    d_done = 0;
    if (owner == 0) begin
      if (dq && !(iREN && streak == SMAX)) owner = 2;
      else if (iREN) owner = 1;
    end else if (ramstate == ACCESS) begin
      if (owner == 1) begin
        streak = 0;
        i_done = 1;
      end else begin
        streak = iREN ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        d_done = 1;
      end
      owner = 0;
    end else if (ramstate == ERROR || (owner == 1 && !iREN) || (owner == 2 && !dq)) begin
      owner = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int saved;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
    ramstate = FREE;

    // Reset values, without and with a pending request
    #12;
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iwait", 32'(iwait), 32'h0);
    chk("rst_dwait", 32'(dwait), 32'h0);
    iREN = 1'b1; dWEN = 1'b1;
    #1;
    chk("rst_iwait_req", 32'(iwait), 32'h1);
    chk("rst_dwait_req", 32'(dwait), 32'h1);
    chk("rst_ramWEN_req", 32'(ramWEN), 32'h0);
    iREN = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Single fetch: arbitration cycle then completion
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h1234_5678;
    sample("t1c1");
    chk("t1_arb_iwait", 32'(iwait), 32'h1);
    tick();
    sample("t1c2");
    chk("t1_ramREN", 32'(ramREN), 32'h1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", 32'(iwait), 32'h0);
    chk("t1_iload", iload, 32'h1234_5678);
    tick();
    iREN = 1'b0; ramstate = FREE;
    sample("t1idle"); tick();

    // Simultaneous requests: data first, then instruction
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h44;
    for (int c = 1; c <= 8; c++) begin
      case (c)
        2, 3, 6, 7: ramstate = BUSY;
        4, 8:       ramstate = ACCESS;
        default:    ramstate = FREE;
      endcase
      if (c == 5) dREN = 1'b0;
      sample("t2");
      if (c == 4) chk("t2_dwait_c4", 32'(dwait), 32'h0);
      if (c == 8) chk("t2_iwait_c8", 32'(iwait), 32'h0);
      tick();
    end
    iREN = 1'b0; ramstate = FREE;
    sample("t2end");
    chk("t2_starve_clr", 32'(dut.starve), 32'h0);
    tick();

    // Starvation guard: four data writes, one forced fetch, data resumes
    iREN = 1'b1; dWEN = 1'b1; ramstate = ACCESS; daddr = 32'h200; dstore = 32'h55;
    for (int c = 1; c <= 12; c++) begin
      sample("t3");
      if (c == 3) chk("t3_starve1", 32'(dut.starve), 32'h1);
      if (c == 9) chk("t3_starve4", 32'(dut.starve), 32'h4);
      if (c == 10) begin
        chk("t3_forced_iwait", 32'(iwait), 32'h0);
        chk("t3_forced_ramWEN", 32'(ramWEN), 32'h0);
      end
      if (c == 11) chk("t3_starve0", 32'(dut.starve), 32'h0);
      if (c == 12) chk("t3_resume_dwait", 32'(dwait), 32'h0);
      tick();
    end
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    sample("t3end"); tick();

    // ERROR retries a data read; starve untouched by the error
    saved = streak;
    dREN = 1'b1; daddr = 32'h300;
    for (int c = 1; c <= 4; c++) begin
      ramstate = (c == 2) ? ERROR : ((c == 4) ? ACCESS : FREE);
      sample("t4");
      if (c == 2) chk("t4_err_dwait", 32'(dwait), 32'h1);
      if (c == 3) chk("t4_err_starve", 32'(dut.starve), 32'(saved));
      if (c == 4) chk("t4_retry_dwait", 32'(dwait), 32'h0);
      tick();
    end
    dREN = 1'b0; ramstate = FREE;
    sample("t4end"); tick();

    // Read and write together is a write
    dREN = 1'b1; dWEN = 1'b1; dstore = 32'hDEAD_BEEF;
    sample("t5c1"); tick();
    ramstate = BUSY;
    sample("t5c2");
    chk("t5_ramWEN", 32'(ramWEN), 32'h1);
    chk("t5_ramREN", 32'(ramREN), 32'h0);
    chk("t5_ramstore", ramstore, 32'hDEAD_BEEF);
    tick();
    ramstate = ACCESS;
    sample("t5c3"); tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    sample("t5end"); tick();

    // Fetch aborted mid-grant
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    sample("t6c1"); tick();
    sample("t6c2"); tick();
    iREN = 1'b0;
    sample("t6c3");
    chk("t6_abort_ramREN", 32'(ramREN), 32'h0);
    tick();
    sample("t6c4");
    chk("t6_idle_ramaddr", ramaddr, 32'h0);
    tick();

    // Reset during a data grant abandons the access
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    sample("t7c1"); tick();
    sample("t7c2");
    #2;
    nRST = 1'b0;
    ramstate = ACCESS;
    #1;
    owner = 0; streak = 0;
    chk("t7_rst_ramREN", 32'(ramREN), 32'h0);
    chk("t7_rst_dwait", 32'(dwait), 32'h1);
    chk("t7_rst_ramaddr", ramaddr, 32'h0);
    chk("t7_rst_starve", 32'(dut.starve), 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
    sample("t7end"); tick();

    // Randomized traffic, requests held until the model reports completion
    for (int c = 0; c < 400; c++) begin
      int r;
      if (!iREN || i_done != 0) begin
        iREN = ($urandom % 3) != 0;
        iaddr = $urandom;
      end else if ($urandom % 20 == 0) begin
        iREN = 1'b0;
      end
      if (!(dREN || dWEN) || d_done != 0) begin
        r = int'($urandom % 4);
        dREN = r[0]; dWEN = r[1];
        daddr = $urandom; dstore = $urandom;
      end else if ($urandom % 20 == 0) begin
        dREN = 1'b0; dWEN = 1'b0;
      end
      r = int'($urandom % 8);
      case (r)
        0, 1:    ramstate = FREE;
        2, 3:    ramstate = BUSY;
        7:       ramstate = ERROR;
        default: ramstate = ACCESS;
      endcase
      ramload = $urandom;
      sample("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
